// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG shift-engine scheduler and its pickers.
package jtag_pkg;

    localparam int unsigned JTAG_LEN_W = 16;
    localparam logic        OP_INSTR   = 1'b0;
    localparam logic        OP_DATA    = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_RUN,
        ST_FINISH
    } sched_state_t;

endpackage

// File: rtl/jtag_rr_pick.sv
// Combinational round-robin picker: first eligible index scanning from ptr upward, wrapping.
module jtag_rr_pick #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int unsigned j;
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        j      = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!valid && eligible[IDX_W'(j)]) begin
                valid = 1'b1;
                idx   = IDX_W'(j);
            end
        end
        if (valid) begin
            winner[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/jtag_scheduler.sv
// Round-robin owner of the single JTAG shift engine: issues work, watches busy,
// and reports per-requester done/err with start and run watchdogs.
module jtag_scheduler
    import jtag_pkg::*;
#(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned LEN_W      = JTAG_LEN_W,
    parameter int unsigned START_WAIT = 4,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_op,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic [N_REQ-1:0]       err,
    output logic [LEN_W-1:0]       len,
    output logic                   op,
    output logic                   work,
    input  logic                   busy,
    output logic                   engine_rst
);

    localparam int unsigned IDX_W    = $clog2(N_REQ);
    localparam int unsigned MAX_WAIT = (TIMEOUT > START_WAIT) ? TIMEOUT : START_WAIT;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (32'(i) == N_REQ - 1) ? '0 : IDX_W'(32'(i) + 1);
    endfunction

    sched_state_t state, state_nxt;

    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             fail, fail_nxt;
    logic [N_REQ-1:0] grant_nxt, done_nxt, err_nxt;
    logic [LEN_W-1:0] len_nxt;
    logic             op_nxt, work_nxt, engine_rst_nxt;

    logic [N_REQ-1:0] eligible, pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [LEN_W-1:0] pick_len;

    // A pulsing done masks its requester so the owner may drop req on that cycle.
    assign eligible = req & ~done;
    assign pick_len = req_len[32'(pick_idx)*LEN_W +: LEN_W];

    jtag_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (pick_oh),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pick_valid && (pick_len != '0)) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE:     state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (busy) begin
                    state_nxt = ST_RUN;
                end else if (cnt == CNT_W'(START_WAIT - 1)) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_RUN: begin
                if (!busy || (cnt == CNT_W'(TIMEOUT - 1))) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH:    state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath.
    always_comb begin
        grant_nxt      = grant;
        done_nxt       = '0;
        err_nxt        = '0;
        len_nxt        = len;
        op_nxt         = op;
        work_nxt       = 1'b0;
        engine_rst_nxt = 1'b0;
        cnt_nxt        = cnt;
        fail_nxt       = fail;
        ptr_nxt        = ptr;
        owner_nxt      = owner;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    if (pick_len != '0) begin
                        grant_nxt = pick_oh;
                        len_nxt   = pick_len;
                        op_nxt    = req_op[pick_idx];
                        owner_nxt = pick_idx;
                        fail_nxt  = 1'b0;
                    end else begin
                        done_nxt = pick_oh;
                        err_nxt  = pick_oh;
                        ptr_nxt  = next_idx(pick_idx);
                    end
                end
            end
            ST_ISSUE: begin
                work_nxt = 1'b1;
                cnt_nxt  = '0;
            end
            ST_WAIT_BUSY: begin
                if (busy) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_W'(START_WAIT - 1)) begin
                    fail_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!busy) begin
                    fail_nxt = 1'b0;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    engine_rst_nxt = 1'b1;
                    fail_nxt       = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_FINISH: begin
                done_nxt[owner] = 1'b1;
                err_nxt[owner]  = fail;
                grant_nxt       = '0;
                ptr_nxt         = next_idx(owner);
            end
            default: begin
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant      <= '0;
            done       <= '0;
            err        <= '0;
            len        <= '0;
            op         <= 1'b0;
            work       <= 1'b0;
            engine_rst <= 1'b0;
            cnt        <= '0;
            fail       <= 1'b0;
            ptr        <= '0;
            owner      <= '0;
        end else begin
            grant      <= grant_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            len        <= len_nxt;
            op         <= op_nxt;
            work       <= work_nxt;
            engine_rst <= engine_rst_nxt;
            cnt        <= cnt_nxt;
            fail       <= fail_nxt;
            ptr        <= ptr_nxt;
            owner      <= owner_nxt;
        end
    end

endmodule
